// File: rtl/rr_arb_mux_if.sv
// Bundle of the producer-side and consumer-side handshake signals of rr_arb_mux.
// A word moves on a channel when valid and ready are both high at a rising clk edge.
// A valid source holds its word until it is taken, and must not wait for ready before raising valid.
interface rr_arb_mux_if #(
  parameter int W = 7,
  parameter int N = 8
);
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  logic           prio_mode;
  logic [W-1:0]   out_data;
  logic           out_valid;
  logic           out_ready;
  logic [N-1:0]   grant;

  // Master is the environment (producers plus consumer); slave is the mux itself.
  modport master (
    output in_data, in_valid, prio_mode, out_ready,
    input  in_ready, out_data, out_valid, grant
  );

  modport slave (
    input  in_data, in_valid, prio_mode, out_ready,
    output in_ready, out_data, out_valid, grant
  );
endinterface

// File: rtl/rr_arb_mux.sv
// N-channel self-arbitrating registered mux: a round-robin or fixed-priority arbiter
// picks one valid channel and loads its word into a single output register.
module rr_arb_mux #(
  parameter int W  = 7,
  parameter int N  = 8,
  localparam int IW = $clog2(N)
) (
  input logic        clk,
  input logic        rst_n,
  rr_arb_mux_if.slave bus
);

  logic [IW-1:0] r_last;
  logic [W-1:0]  r_out_data;
  logic          r_out_valid;
  logic [N-1:0]  r_grant;

  logic          w_load_en;
  logic          w_rr_found;
  logic [IW-1:0] w_rr_win;
  logic [IW-1:0] w_rr_idx;
  logic          w_fx_found;
  logic [IW-1:0] w_fx_win;
  logic          w_found;
  logic [IW-1:0] w_winner;
  logic [N-1:0]  w_onehot;
  logic [W-1:0]  w_sel_data;

  assign w_load_en = !r_out_valid || bus.out_ready;

  // Round-robin search starts just after the last winner; the wrap is an explicit
  // compare so non-power-of-two N never visits a non-existent channel.
  always_comb begin
    w_rr_found = 1'b0;
    w_rr_win   = '0;
    w_rr_idx   = r_last;
    for (int k = 0; k < N; k++) begin
      w_rr_idx = (w_rr_idx == IW'(N - 1)) ? '0 : w_rr_idx + 1'b1;
      if (!w_rr_found && bus.in_valid[w_rr_idx]) begin
        w_rr_found = 1'b1;
        w_rr_win   = w_rr_idx;
      end
    end
  end

  always_comb begin
    w_fx_found = 1'b0;
    w_fx_win   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (bus.in_valid[i]) begin
        w_fx_found = 1'b1;
        w_fx_win   = IW'(i);
      end
    end
  end

  assign w_found  = bus.prio_mode ? w_fx_found : w_rr_found;
  assign w_winner = bus.prio_mode ? w_fx_win   : w_rr_win;

  always_comb begin
    w_onehot   = '0;
    w_sel_data = '0;
    for (int i = 0; i < N; i++) begin
      if (w_winner == IW'(i)) begin
        w_onehot[i] = w_found;
        w_sel_data  = bus.in_data[i*W +: W];
      end
    end
  end

  // Gating with rst_n keeps any handshake from completing while reset is held.
  assign bus.in_ready = (rst_n && w_load_en) ? w_onehot : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last      <= IW'(N - 1);
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_grant     <= '0;
    end else if (w_load_en) begin
      if (w_found) begin
        r_out_data  <= w_sel_data;
        r_grant     <= w_onehot;
        r_out_valid <= 1'b1;
        r_last      <= w_winner;
      end else begin
        r_out_valid <= 1'b0;
        r_grant     <= '0;
      end
    end
  end

  assign bus.out_data  = r_out_data;
  assign bus.out_valid = r_out_valid;
  assign bus.grant     = r_grant;

endmodule

// File: tb/tb_rr_arb_mux.sv
// Directed bench for rr_arb_mux: driver pushes hand-computed {grant,data} words into a
// queue, a negedge monitor pops one per output transfer; direct checks cover handshake timing.
module tb_rr_arb_mux;
  localparam int W = 7;
  localparam int N = 8;

  logic clk;
  logic rst_n;

  rr_arb_mux_if #(.W(W), .N(N)) bus ();

  rr_arb_mux #(.W(W), .N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total;
  int bad;
  logic [N+W-1:0] exp_q[$];

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, queue depth %0d", exp_q.size());
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int ch, input logic [W-1:0] d);
    bus.in_data[ch*W +: W] = d;
  endtask

  task automatic expect_word(input logic [N-1:0] g, input logic [W-1:0] d);
    exp_q.push_back({g, d});
  endtask

  // scoreboard monitor: one pop per completed output transfer
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_underflow: got %0h with no expected word", {bus.grant, bus.out_data});
      end else begin
        chk("sb_word", 32'({bus.grant, bus.out_data}), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.in_data   = '0;
    bus.in_valid  = '0;
    bus.prio_mode = 1'b0;
    bus.out_ready = 1'b0;

    // 1: reset, then a single request on ch2
    step();
    bus.in_valid  = 8'hFF;
    bus.out_ready = 1'b1;
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'h0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_grant", 32'(bus.grant), 32'h0);
    chk("rst_out_data", 32'(bus.out_data), 32'h0);
    step();
    step();
    rst_n = 1'b1;
    bus.in_valid = 8'b0000_0100;
    set_ch(2, 7'h55);
    #1;
    chk("t1_in_ready", 32'(bus.in_ready), 32'h04);
    expect_word(8'h04, 7'h55);
    step();
    chk("t1_out_valid", 32'(bus.out_valid), 32'h1);
    chk("t1_out_data", 32'(bus.out_data), 32'h55);
    chk("t1_grant", 32'(bus.grant), 32'h04);

    // 2: park the pointer on ch7, then all channels valid -> 1..8,1
    for (int i = 0; i < N; i++) set_ch(i, 7'(i + 1));
    bus.in_valid = 8'h80;
    expect_word(8'h80, 7'd8);
    step();
    bus.in_valid = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      #1;
      chk("t2_in_ready", 32'(bus.in_ready), 32'(8'h01 << (k % 8)));
      expect_word(8'h01 << (k % 8), 7'((k % 8) + 1));
      step();
      chk("t2_grant", 32'(bus.grant), 32'(8'h01 << (k % 8)));
    end

    // 3: fixed priority, ch7 starves
    bus.prio_mode = 1'b1;
    bus.in_valid  = 8'b1010_0000;
    #1;
    chk("t3_in_ready_ch5", 32'(bus.in_ready), 32'h20);
    expect_word(8'h20, 7'd6);
    step();
    bus.in_valid = 8'b1010_0001;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("t3_in_ready_ch0", 32'(bus.in_ready), 32'h01);
      expect_word(8'h01, 7'd1);
      step();
    end
    bus.in_valid = 8'b1010_0000;
    expect_word(8'h20, 7'd6);
    step();

    // 4: backpressure holding a ch3 word, then release with no bubble
    bus.prio_mode = 1'b0;
    set_ch(3, 7'h2A);
    bus.in_valid = 8'h08;
    expect_word(8'h08, 7'h2A);
    step();
    bus.out_ready = 1'b0;
    bus.in_valid  = 8'hFF;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("t4_bp_in_ready", 32'(bus.in_ready), 32'h0);
      chk("t4_bp_out_data", 32'(bus.out_data), 32'h2A);
      chk("t4_bp_grant", 32'(bus.grant), 32'h08);
      chk("t4_bp_out_valid", 32'(bus.out_valid), 32'h1);
      step();
    end
    bus.out_ready = 1'b1;
    #1;
    chk("t4_release_in_ready", 32'(bus.in_ready), 32'h10);
    expect_word(8'h10, 7'd5);
    step();
    chk("t4_release_grant", 32'(bus.grant), 32'h10);
    chk("t4_release_valid", 32'(bus.out_valid), 32'h1);

    // 5: drain to empty
    bus.in_valid = 8'h00;
    step();
    chk("t5_out_valid", 32'(bus.out_valid), 32'h0);
    chk("t5_grant", 32'(bus.grant), 32'h0);
    chk("t5_out_data_hold", 32'(bus.out_data), 32'h05);

    // 6: asynchronous reset with a held ch6 word
    bus.in_valid = 8'h40;
    expect_word(8'h40, 7'd7);
    step();
    bus.out_ready = 1'b0;
    bus.in_valid  = 8'h00;
    chk("t6_pre_grant", 32'(bus.grant), 32'h40);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("t6_async_valid", 32'(bus.out_valid), 32'h0);
    chk("t6_async_grant", 32'(bus.grant), 32'h0);
    #1;
    rst_n = 1'b1;
    bus.in_valid  = 8'hFF;
    bus.out_ready = 1'b1;
    #1;
    chk("t6_first_in_ready", 32'(bus.in_ready), 32'h01);
    expect_word(8'h01, 7'd1);
    step();
    chk("t6_first_grant", 32'(bus.grant), 32'h01);
    bus.in_valid = 8'h00;
    step();
    step();

    chk("sb_queue_empty", 32'(exp_q.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
